// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the responder state encoding and the word/byte-lane geometry used by
// dmem_responder and its byte-writable word array.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned LANE_W    = 8;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_LANES = WORD_W / LANE_W;

endpackage

// File: rtl/bytewe_sram.sv
// Byte-writable word array with a synchronous read port.
// Ports:
//   clk    - clock
//   en     - access enable; performs a write (we=1) or a read (we=0)
//   we     - write select
//   mask   - per-lane write enable, bit i covers wdata[8i+7:8i]
//   addr   - word index
//   wdata  - lane-aligned write data
//   rdata  - read data, registered on the enabled read edge
// Contents are not reset; rdata holds its value between reads.
module bytewe_sram
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [NUM_LANES-1:0] mask,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (mask[i]) begin
                        mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory-stage load/store port.
// Accepts one request at a time, holds it for LAT cycles, then commits the
// store lanes or returns the loaded word with a one-cycle resp_valid pulse.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   req_valid   - request present (held by initiator until accepted)
//   req_we      - 1 = store, 0 = load
//   req_sel     - byte enables
//   req_addr    - byte address; bits [1:0] are ignored
//   req_wdata   - lane-aligned store data
//   req_ready   - responder can accept this cycle
//   resp_valid  - one-cycle completion pulse
//   resp_rdata  - load data during resp_valid, otherwise 0
//   addr_err    - out-of-range flag, only during resp_valid
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [NUM_LANES-1:0] req_sel,
    input  logic [31:0]          req_addr,
    input  logic [WORD_W-1:0]    req_wdata,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic [WORD_W-1:0]    resp_rdata,
    output logic                 addr_err
);

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   we_q;
    logic [NUM_LANES-1:0]   sel_q;
    logic [WORD_W-1:0]      wdata_q;
    logic [ADDR_W-1:0]      idx_q;
    logic                   oor_q;

    logic                   accept;
    logic                   commit;
    logic [ADDR_W-1:0]      in_idx;
    logic                   in_oor;
    logic                   cur_we;
    logic [NUM_LANES-1:0]   cur_sel;
    logic [WORD_W-1:0]      cur_wdata;
    logic [ADDR_W-1:0]      cur_idx;
    logic                   cur_oor;
    logic [WORD_W-1:0]      sram_rdata;
    logic                   unused_addr;

    assign unused_addr = ^req_addr[1:0];

    assign in_idx = req_addr[ADDR_W+1:2];
    assign in_oor = |req_addr[31:ADDR_W+2];

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // With LAT=1 the commit edge is the acceptance edge, so the array must see
    // the incoming request directly instead of the latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = req_we;
            cur_sel   = req_sel;
            cur_wdata = req_wdata;
            cur_idx   = in_idx;
            cur_oor   = in_oor;
        end else begin
            cur_we    = we_q;
            cur_sel   = sel_q;
            cur_wdata = wdata_q;
            cur_idx   = idx_q;
            cur_oor   = oor_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LAT > 1) begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                sel_q   <= req_sel;
                wdata_q <= req_wdata;
                idx_q   <= in_idx;
                oor_q   <= in_oor;
            end
        end
    end

    // Reset on the commit edge aborts the access, so the array is gated by rst.
    bytewe_sram #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk   (clk),
        .en    (commit && !rst && !cur_oor),
        .we    (cur_we),
        .mask  (cur_sel),
        .addr  (cur_idx),
        .wdata (cur_wdata),
        .rdata (sram_rdata)
    );

    assign resp_valid = (state_q == RESP);
    assign addr_err   = (state_q == RESP) && oor_q;
    assign resp_rdata = ((state_q == RESP) && !we_q && !oor_q) ? sram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LAT=2 and LAT=1) driven by directed
// requests, checked every cycle against a transaction-level memory model plus
// hand-computed literal expectations.
module tb_dmem_responder;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_we     [2];
    logic [3:0]  req_sel    [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        addr_err   [2];

    dmem_responder #(.ADDR_W(10), .LAT(LAT0)) u_dut0 (
        .clk        (clk),
        .rst        (rst[0]),
        .req_valid  (req_valid[0]),
        .req_we     (req_we[0]),
        .req_sel    (req_sel[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .req_ready  (req_ready[0]),
        .resp_valid (resp_valid[0]),
        .resp_rdata (resp_rdata[0]),
        .addr_err   (addr_err[0])
    );

    dmem_responder #(.ADDR_W(10), .LAT(LAT1)) u_dut1 (
        .clk        (clk),
        .rst        (rst[1]),
        .req_valid  (req_valid[1]),
        .req_we     (req_we[1]),
        .req_sel    (req_sel[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .req_ready  (req_ready[1]),
        .resp_valid (resp_valid[1]),
        .resp_rdata (resp_rdata[1]),
        .addr_err   (addr_err[1])
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    // ---------------- transaction-level model ----------------
    // An accepted request is outstanding for LAT edges counting the acceptance
    // edge; on the last of those it takes effect and the next cycle is the
    // response cycle. The memory is a plain array of words.
    bit          armed  [2];
    bit          pend   [2];
    int          remain [2];
    bit          m_we   [2];
    logic [3:0]  m_sel  [2];
    logic [31:0] m_wd   [2];
    int          m_idx  [2];
    bit          m_oor  [2];
    bit          rnow   [2];
    logic [31:0] rdat   [2];
    bit          rerr   [2];
    logic [31:0] mem_m  [2][1024];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (armed[i]) begin
                check($sformatf("req_ready[%0d]", i), 32'(req_ready[i]),
                      32'(!rst[i] && !pend[i] && !rnow[i]));
                check($sformatf("resp_valid[%0d]", i), 32'(resp_valid[i]), 32'(rnow[i]));
                check($sformatf("resp_rdata[%0d]", i), resp_rdata[i], rnow[i] ? rdat[i] : 32'h0);
                check($sformatf("addr_err[%0d]", i), 32'(addr_err[i]), 32'(rnow[i] && rerr[i]));
            end
            // Predict what the coming edge does.
            if (rst[i]) begin
                armed[i] = 1'b1;
                pend[i]  = 1'b0;
                rnow[i]  = 1'b0;
            end else if (armed[i]) begin
                bit rnext;
                rnext = 1'b0;
                if (!pend[i] && !rnow[i] && req_valid[i]) begin
                    pend[i]   = 1'b1;
                    remain[i] = lat_of(i);
                    m_we[i]   = req_we[i];
                    m_sel[i]  = req_sel[i];
                    m_wd[i]   = req_wdata[i];
                    m_idx[i]  = int'(req_addr[i][11:2]);
                    m_oor[i]  = (req_addr[i] >= 32'h1000);
                end
                if (pend[i]) begin
                    remain[i]--;
                    if (remain[i] == 0) begin
                        pend[i] = 1'b0;
                        rnext   = 1'b1;
                        rerr[i] = m_oor[i];
                        rdat[i] = 32'h0;
                        if (!m_oor[i]) begin
                            if (m_we[i]) begin
                                for (int b = 0; b < 4; b++)
                                    if (m_sel[i][b])
                                        mem_m[i][m_idx[i]][8*b +: 8] = m_wd[i][8*b +: 8];
                            end else begin
                                rdat[i] = mem_m[i][m_idx[i]];
                            end
                        end
                    end
                end
                rnow[i] = rnext;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input int i, input bit we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat_obs);
        bit acc;
        bit got;
        int acc_cyc;
        acc = 1'b0;
        got = 1'b0;
        acc_cyc = 0;
        rd = 32'h0;
        err = 1'b0;
        lat_obs = -1;
        @(posedge clk);
        #1;
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_sel[i]   = sel;
        req_addr[i]  = addr;
        req_wdata[i] = wd;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            if (req_ready[i]) acc = 1'b1;
        end
        check("accept_within_bound", 32'(acc), 32'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        req_valid[i] = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (resp_valid[i]) begin
                got = 1'b1;
                rd  = resp_rdata[i];
                err = addr_err[i];
                lat_obs = cyc - acc_cyc + 1;
            end
        end
        check("resp_within_bound", 32'(got), 32'd1);
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            req_valid[i] = 1'b0;
            req_we[i] = 1'b0;
            req_sel[i] = 4'h0;
            req_addr[i] = 32'h0;
            req_wdata[i] = 32'h0;
        end

        // Reset for 3 cycles, ready in the first cycle after release.
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        check("ready_after_reset0", 32'(req_ready[0]), 32'd1);
        check("ready_after_reset1", 32'(req_ready[1]), 32'd1);

        // Word store then load, LAT=2.
        do_req(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, err, lat);
        check("store_latency", 32'(lat), 32'd2);
        check("store_rdata_zero", rd, 32'h0);
        do_req(0, 1'b0, 4'hF, 32'h10, 32'h0, rd, err, lat);
        check("load_word", rd, 32'hDEADBEEF);
        check("load_no_err", 32'(err), 32'd0);

        // Single byte lane 2.
        do_req(0, 1'b1, 4'b0100, 32'h10, 32'h00AA0000, rd, err, lat);
        do_req(0, 1'b0, 4'hF, 32'h10, 32'h0, rd, err, lat);
        check("load_byte_merge", rd, 32'hDEAABEEF);

        // Empty byte mask still acknowledged, nothing written.
        do_req(0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, rd, err, lat);
        check("sel0_latency", 32'(lat), 32'd2);
        do_req(0, 1'b0, 4'hF, 32'h10, 32'h0, rd, err, lat);
        check("sel0_unchanged", rd, 32'hDEAABEEF);

        // Out-of-range load and store.
        do_req(0, 1'b0, 4'hF, 32'h1000, 32'h0, rd, err, lat);
        check("oor_load_err", 32'(err), 32'd1);
        check("oor_load_rdata", rd, 32'h0);
        check("oor_load_latency", 32'(lat), 32'd2);
        do_req(0, 1'b1, 4'hF, 32'h1010, 32'h12345678, rd, err, lat);
        check("oor_store_err", 32'(err), 32'd1);
        do_req(0, 1'b0, 4'hF, 32'h10, 32'h0, rd, err, lat);
        check("oor_store_no_alias", rd, 32'hDEAABEEF);

        // Back-to-back loads with req_valid held high.
        begin
            int nacc;
            int npulse;
            int acc_at [3];
            nacc = 0;
            npulse = 0;
            acc_at = '{0, 0, 0};
            @(posedge clk);
            #1;
            req_valid[0] = 1'b1;
            req_we[0] = 1'b0;
            req_sel[0] = 4'hF;
            req_addr[0] = 32'h10;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (resp_valid[0]) npulse++;
                if (req_valid[0] && req_ready[0] && nacc < 3) begin
                    acc_at[nacc] = cyc;
                    nacc++;
                    if (nacc == 3) begin
                        @(posedge clk);
                        #1;
                        req_valid[0] = 1'b0;
                    end
                end
            end
            check("b2b_accepts", 32'(nacc), 32'd3);
            check("b2b_gap1", 32'(acc_at[1] - acc_at[0]), 32'd3);
            check("b2b_gap2", 32'(acc_at[2] - acc_at[1]), 32'd3);
            check("b2b_pulses", 32'(npulse), 32'd3);
        end

        // Reset during a LAT=2 store before its commit edge.
        do_req(0, 1'b1, 4'hF, 32'h20, 32'h5555AAAA, rd, err, lat);
        begin
            bit acc;
            int npulse;
            acc = 1'b0;
            npulse = 0;
            @(posedge clk);
            #1;
            req_valid[0] = 1'b1;
            req_we[0] = 1'b1;
            req_sel[0] = 4'hF;
            req_addr[0] = 32'h20;
            req_wdata[0] = 32'h11111111;
            for (int k = 0; k < 20 && !acc; k++) begin
                @(negedge clk);
                if (req_ready[0]) acc = 1'b1;
            end
            check("abort_accept", 32'(acc), 32'd1);
            @(posedge clk);
            #1;
            req_valid[0] = 1'b0;
            rst[0] = 1'b1;
            @(posedge clk);
            #1;
            rst[0] = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (resp_valid[0]) npulse++;
            end
            check("abort_no_resp", 32'(npulse), 32'd0);
        end
        do_req(0, 1'b0, 4'hF, 32'h20, 32'h0, rd, err, lat);
        check("abort_not_written", rd, 32'h5555AAAA);

        // LAT=1: reset in the response cycle, store already committed.
        do_req(1, 1'b1, 4'hF, 32'h20, 32'h5555AAAA, rd, err, lat);
        check("lat1_latency", 32'(lat), 32'd1);
        begin
            bit acc;
            acc = 1'b0;
            @(posedge clk);
            #1;
            req_valid[1] = 1'b1;
            req_we[1] = 1'b1;
            req_sel[1] = 4'hF;
            req_addr[1] = 32'h20;
            req_wdata[1] = 32'h11111111;
            for (int k = 0; k < 20 && !acc; k++) begin
                @(negedge clk);
                if (req_ready[1]) acc = 1'b1;
            end
            check("lat1_accept", 32'(acc), 32'd1);
            @(posedge clk);
            #1;
            req_valid[1] = 1'b0;
            rst[1] = 1'b1;
            @(negedge clk);
            check("lat1_resp_cycle", 32'(resp_valid[1]), 32'd1);
            @(posedge clk);
            #1;
            rst[1] = 1'b0;
        end
        do_req(1, 1'b0, 4'hF, 32'h20, 32'h0, rd, err, lat);
        check("lat1_committed", rd, 32'h11111111);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
